pipe_stage_reg: RTL and testbench

- Generic, parametrised pipeline stage register. It generalises the fixed per-stage DFF banks (if_id, id_ex, ex_mem, ...) into one block.
- The payload is a single flat bus of DATA_W bits. Each stage packs its own fields (pc, operands, rd, decode info, CSR) into that bus.
- Adds a valid/ready handshake and an optional one-entry skid buffer, so back-pressure does not need a combinational ready path through the stage.
- Keeps compatibility with the ctrl stall/flush vectors and adds a saturating stall-cycle counter for performance monitoring.

---
 rtl/pipe_stage_reg_pkg.sv | 19 +
 rtl/pipe_stage_reg_entry.sv | 30 +++
 rtl/pipe_stage_reg.sv | 135 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants for the generic pipeline stage register: stage indices,
// default ctrl vector widths and the occupancy encodings of a stage.
package pipe_stage_reg_pkg;

  localparam int STG_IF     = 0;
  localparam int STG_ID     = 1;
  localparam int STG_ID_EX  = 2;
  localparam int STG_EX_MEM = 3;
  localparam int STG_MEM_WB = 4;

  localparam int STALL_W_DEF = 6;
  localparam int FLUSH_W_DEF = 5;

  // Occupancy is encoded as {skid_valid, main_valid}, so no separate state register exists.
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b11;

endpackage

// File: rtl/pipe_stage_reg_entry.sv
// One valid+data holding register with asynchronous reset.
// A clear takes priority over a load.
module pipe_stage_reg_entry #(
  parameter int DATA_W      = 32,
  parameter int ZERO_ON_CLR = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clr,
  input  logic [DATA_W-1:0] d,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (clr) begin
      valid <= 1'b0;
      // A zeroed payload decodes as a nop in every stage.
      if (ZERO_ON_CLR != 0) data <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: valid/ready handshake, optional skid entry,
// ctrl stall/flush compatibility and a saturating stall-cycle counter.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int STAGE_IDX   = STG_ID_EX,
  parameter int STALL_W     = STALL_W_DEF,
  parameter int FLUSH_W     = FLUSH_W_DEF,
  parameter int SKID_EN     = 1,
  parameter int ZERO_ON_CLR = 1,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [STALL_W-1:0] stall_i,
  input  logic [FLUSH_W-1:0] flush_i,
  input  logic               in_valid_i,
  input  logic [DATA_W-1:0]  in_data_i,
  output logic               in_ready_o,
  output logic               out_valid_o,
  output logic [DATA_W-1:0]  out_data_o,
  input  logic               out_ready_i,
  output logic [CNT_W-1:0]   stall_cnt_o,
  input  logic               cnt_clr_i
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              up_hold, dn_hold, fl;
  logic              accept, drain;
  logic              main_valid, skid_valid;
  logic [DATA_W-1:0] main_data, skid_data, main_d;
  logic              main_load, main_clr, main_from_skid;
  logic              skid_load, skid_clr;
  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt_reg;
  logic              unused_ctrl;

  assign up_hold = stall_i[STAGE_IDX];
  assign dn_hold = stall_i[STAGE_IDX+1];
  assign fl      = flush_i[STAGE_IDX];
  // Other stages' ctrl bits are intentionally ignored here.
  assign unused_ctrl = ^{stall_i, flush_i};

  if (SKID_EN != 0) begin : g_ready_skid
    assign in_ready_o = !skid_valid && !up_hold;
  end else begin : g_ready_comb
    assign in_ready_o = (!main_valid || (out_ready_i && !dn_hold)) && !up_hold;
  end

  assign accept = in_valid_i && in_ready_o;
  assign drain  = main_valid && out_ready_i && !dn_hold;
  assign state  = {skid_valid, main_valid};

  // Bubble insertion is the ONE/drain/no-accept case: main clears behind the drain.
  always_comb begin
    main_load      = 1'b0;
    main_clr       = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clr       = 1'b0;
    if (fl) begin
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (state)
        ST_EMPTY: main_load = accept;
        ST_ONE: begin
          if (accept && drain)  main_load = 1'b1;
          else if (accept)      skid_load = 1'b1;
          else if (drain)       main_clr  = 1'b1;
        end
        ST_FULL: begin
          if (drain) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign main_d = main_from_skid ? skid_data : in_data_i;

  pipe_stage_reg_entry #(
    .DATA_W      (DATA_W),
    .ZERO_ON_CLR (ZERO_ON_CLR)
  ) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (main_load),
    .clr   (main_clr),
    .d     (main_d),
    .valid (main_valid),
    .data  (main_data)
  );

  if (SKID_EN != 0) begin : g_skid
    pipe_stage_reg_entry #(
      .DATA_W      (DATA_W),
      .ZERO_ON_CLR (ZERO_ON_CLR)
    ) u_skid (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (skid_load),
      .clr   (skid_clr),
      .d     (in_data_i),
      .valid (skid_valid),
      .data  (skid_data)
    );
  end else begin : g_no_skid
    logic unused_skid;
    assign skid_valid  = 1'b0;
    assign skid_data   = '0;
    assign unused_skid = skid_load | skid_clr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (cnt_clr_i) begin
      cnt_reg <= '0;
    end else if ((up_hold || (in_valid_i && !in_ready_o)) && cnt_reg != CNT_MAX) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign out_valid_o = main_valid;
  assign out_data_o  = main_data;
  assign stall_cnt_o = cnt_reg;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg (DATA_W=32, STAGE_IDX=2, SKID_EN=1,
// ZERO_ON_CLR=1, CNT_W=4) with hand-computed expectations.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  stall;
  logic [4:0]  flush;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic [3:0]  stall_cnt;
  logic        cnt_clr;

  int checks = 0;
  int errors = 0;

  pipe_stage_reg #(
    .DATA_W(32), .STAGE_IDX(2), .STALL_W(6), .FLUSH_W(5),
    .SKID_EN(1), .ZERO_ON_CLR(1), .CNT_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall), .flush_i(flush),
    .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready),
    .out_valid_o(out_valid), .out_data_o(out_data), .out_ready_i(out_ready),
    .stall_cnt_o(stall_cnt), .cnt_clr_i(cnt_clr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end else begin
      $display("ok   %s = %h", name, got);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = '0; flush = '0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b0; cnt_clr = 1'b0;
    #2;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_out_data", out_data, 32'd0);
    chk("reset_stall_cnt", {28'd0, stall_cnt}, 32'd0);
    step();
    rst_n = 1'b1;
    #1;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic test_basic();
    logic [31:0] vals [3];
    vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = vals[i];
      step();
      chk("basic_out_valid", {31'd0, out_valid}, 32'd1);
      chk("basic_out_data", out_data, vals[i]);
      chk("basic_in_ready", {31'd0, in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    step();
    chk("basic_drained_valid", {31'd0, out_valid}, 32'd0);
    chk("basic_stall_cnt", {28'd0, stall_cnt}, 32'd0);
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA;
    step();
    chk("bp_main_a", out_data, 32'hA);
    in_data = 32'hB;
    step();
    chk("bp_ready_low", {31'd0, in_ready}, 32'd0);
    chk("bp_hold_a", out_data, 32'hA);
    in_data = 32'hC;
    step();
    chk("bp_still_a", out_data, 32'hA);
    chk("bp_c_refused", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    step();
    chk("bp_release_b", out_data, 32'hB);
    chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
    step();
    chk("bp_release_c", out_data, 32'hC);
    in_valid = 1'b0;
    step();
    chk("bp_empty", {31'd0, out_valid}, 32'd0);
    chk("bp_stall_cnt", {28'd0, stall_cnt}, 32'd2);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("bp_cnt_cleared", {28'd0, stall_cnt}, 32'd0);
  endtask

  task automatic test_bubble();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h55;
    step();
    in_valid = 1'b0; stall = 6'b000100; out_ready = 1'b1;
    #1;
    chk("bubble_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    chk("bubble_out_valid", {31'd0, out_valid}, 32'd0);
    chk("bubble_out_data", out_data, 32'd0);
    chk("bubble_stall_cnt", {28'd0, stall_cnt}, 32'd1);
    stall = 6'b000000;
  endtask

  task automatic test_dn_hold();
    in_valid = 1'b1; in_data = 32'h66; out_ready = 1'b1;
    step();
    in_valid = 1'b0; stall = 6'b001000;
    step();
    chk("dnhold_valid", {31'd0, out_valid}, 32'd1);
    chk("dnhold_data", out_data, 32'h66);
    stall = 6'b000000;
    step();
    chk("dnhold_drained", {31'd0, out_valid}, 32'd0);
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h1;
    step();
    in_data = 32'h2;
    step();
    in_data = 32'h3; flush = 5'b00100;
    step();
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_out_data", out_data, 32'd0);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    flush = '0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("flush_3_dropped", {31'd0, out_valid}, 32'd0);
    in_valid = 1'b1; in_data = 32'h44; flush = 5'b00100;
    step();
    chk("flush_accept_dropped", {31'd0, out_valid}, 32'd0);
    chk("flush_cnt_kept", {28'd0, stall_cnt}, 32'd2);
    flush = '0; in_valid = 1'b0;
  endtask

  task automatic test_saturation();
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    stall = 6'b000100;
    for (int i = 0; i < 20; i++) step();
    chk("sat_value", {28'd0, stall_cnt}, 32'd15);
    cnt_clr = 1'b1;
    step();
    chk("sat_clr_priority", {28'd0, stall_cnt}, 32'd0);
    cnt_clr = 1'b0;
    step();
    chk("sat_restart", {28'd0, stall_cnt}, 32'd1);
    stall = 6'b000000;
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h1;
    step();
    in_data = 32'h2;
    step();
    in_valid = 1'b0;
    chk("areset_full_main", out_data, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("areset_out_data", out_data, 32'd0);
    chk("areset_stall_cnt", {28'd0, stall_cnt}, 32'd0);
    step();
    rst_n = 1'b1;
    #1;
    chk("areset_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_bubble();
    test_dn_hold();
    test_flush();
    test_saturation();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
